// File: rtl/yyh_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : yyh_seg_capture
// Brief    : Samples a multiplexed active-low 7-segment bus, waits for each
//            digit to settle and recovers BCD digits, flagging illegal glyphs.
// Revision : 1.0 - initial release
// ============================================================================
module yyh_seg_capture #(
    parameter int N_DIG      = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         seg,
    input  logic [N_DIG-1:0]   dig_n,
    output logic [4*N_DIG-1:0] dout,
    output logic [N_DIG-1:0]   dvalid,
    output logic               bad,
    output logic               frame,
    output logic [7:0]         err_cnt
);

    localparam int         c_IW       = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [7:0] c_CNT_LAST = 8'(STABLE_CYC - 1);
    localparam logic [6:0] c_BLANK    = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [6:0]        r_seg_q;
    logic [N_DIG-1:0]  r_dig_q;
    logic [6:0]        r_cand_seg;
    logic [c_IW-1:0]   r_cand_idx;
    logic [7:0]        r_cnt;
    logic [N_DIG-1:0]  r_seen;

    logic              w_legal;
    logic [c_IW-1:0]   w_idx;
    logic [3:0]        w_lows;
    logic              w_match;
    logic              w_load;
    logic              w_capture;
    logic [3:0]        w_code;
    logic              w_is_digit;
    logic              w_is_blank;
    logic [N_DIG-1:0]  w_seen_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_q <= c_BLANK;
            r_dig_q <= '1;
        end else begin
            r_seg_q <= seg;
            r_dig_q <= dig_n;
        end
    end

    // Strobe is legal only with exactly one line pulled low.
    always_comb begin
        w_lows = 4'd0;
        w_idx  = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (!r_dig_q[i]) begin
                w_lows = w_lows + 4'd1;
                w_idx  = c_IW'(i);
            end
        end
        w_legal = (w_lows == 4'd1);
    end

    assign w_match = w_legal && (w_idx == r_cand_idx) && (r_seg_q == r_cand_seg);

    always_comb begin
        w_code     = 4'd0;
        w_is_digit = 1'b1;
        w_is_blank = 1'b0;
        case (r_cand_seg)
            7'h40:   w_code = 4'd0;
            7'h79:   w_code = 4'd1;
            7'h24:   w_code = 4'd2;
            7'h30:   w_code = 4'd3;
            7'h19:   w_code = 4'd4;
            7'h12:   w_code = 4'd5;
            7'h02:   w_code = 4'd6;
            7'h78:   w_code = 4'd7;
            7'h00:   w_code = 4'd8;
            7'h10:   w_code = 4'd9;
            c_BLANK: begin
                w_is_digit = 1'b0;
                w_is_blank = 1'b1;
            end
            default: w_is_digit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_legal) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE, S_HOLD: begin
                if (w_match) begin
                    if (r_state == S_SETTLE && r_cnt == c_CNT_LAST) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (w_legal) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SETTLE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand_seg <= c_BLANK;
            r_cand_idx <= '0;
            r_cnt      <= 8'd0;
        end else if (w_load) begin
            r_cand_seg <= r_seg_q;
            r_cand_idx <= w_idx;
            r_cnt      <= 8'd1;
        end else if (r_state == S_SETTLE && w_match && !w_capture) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign w_seen_set = r_seen | (N_DIG'(1) << r_cand_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= '0;
            dvalid  <= '0;
            bad     <= 1'b0;
            frame   <= 1'b0;
            err_cnt <= 8'd0;
            r_seen  <= '0;
        end else begin
            bad   <= 1'b0;
            frame <= 1'b0;
            if (w_capture) begin
                if (w_is_digit) begin
                    dout[r_cand_idx*4 +: 4] <= w_code;
                    dvalid[r_cand_idx]      <= 1'b1;
                end else begin
                    dvalid[r_cand_idx] <= 1'b0;
                    if (!w_is_blank) begin
                        bad <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                // A complete set of digits closes the frame and starts a new one.
                if (w_seen_set == {N_DIG{1'b1}}) begin
                    frame  <= 1'b1;
                    r_seen <= '0;
                end else begin
                    r_seen <= w_seen_set;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_yyh_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_yyh_seg_capture
// Brief    : Self-checking bench for yyh_seg_capture against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_yyh_seg_capture;

    localparam int N_DIG      = 4;
    localparam int STABLE_CYC = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [6:0]  seg   = 7'h7F;
    logic [3:0]  dig_n = 4'hF;
    logic [15:0] dout;
    logic [3:0]  dvalid;
    logic        bad;
    logic        frame;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    yyh_seg_capture #(
        .N_DIG      (N_DIG),
        .STABLE_CYC (STABLE_CYC)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .seg     (seg),
        .dig_n   (dig_n),
        .dout    (dout),
        .dvalid  (dvalid),
        .bad     (bad),
        .frame   (frame),
        .err_cnt (err_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;
    int frame_cnt = 0;
    int bad_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic int decode(input logic [6:0] s);
        case (s)
            7'h40: return 0;
            7'h79: return 1;
            7'h24: return 2;
            7'h30: return 3;
            7'h19: return 4;
            7'h12: return 5;
            7'h02: return 6;
            7'h78: return 7;
            7'h00: return 8;
            7'h10: return 9;
            default: return -1;
        endcase
    endfunction

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Model: a capture happens when a legal (seg, strobe) sample pair has been
    // seen STABLE_CYC times in a row; one capture per run.
    logic [15:0] m_dout;
    logic [3:0]  m_dvalid;
    logic        m_bad;
    logic        m_frame;
    int          m_err;
    logic [3:0]  m_seen;
    logic [6:0]  m_seg_q;
    logic [3:0]  m_dig_q;
    logic [6:0]  m_last_seg;
    logic [3:0]  m_last_dig;
    int          m_run;
    bit          m_live = 1'b0;

    initial begin
        int pos;
        int code;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_dout   = '0;
                m_dvalid = '0;
                m_bad    = 1'b0;
                m_frame  = 1'b0;
                m_err    = 0;
                m_seen   = '0;
                m_run    = 0;
                m_seg_q  = 7'h7F;
                m_dig_q  = 4'hF;
                m_live   = 1'b1;
            end else if (m_live) begin
                m_bad   = 1'b0;
                m_frame = 1'b0;
                if ($countones(~m_dig_q) == 1) begin
                    if (m_run > 0 && m_dig_q == m_last_dig && m_seg_q == m_last_seg) m_run++;
                    else m_run = 1;
                    m_last_dig = m_dig_q;
                    m_last_seg = m_seg_q;
                    if (m_run == STABLE_CYC) begin
                        pos = 0;
                        for (int i = 0; i < N_DIG; i++) if (!m_dig_q[i]) pos = i;
                        code = decode(m_seg_q);
                        if (code >= 0) begin
                            m_dout[pos*4 +: 4] = 4'(code);
                            m_dvalid[pos] = 1'b1;
                        end else begin
                            m_dvalid[pos] = 1'b0;
                            if (m_seg_q != 7'h7F) begin
                                m_bad = 1'b1;
                                if (m_err < 255) m_err++;
                            end
                        end
                        m_seen[pos] = 1'b1;
                        if (m_seen == 4'hF) begin
                            m_frame = 1'b1;
                            m_seen  = '0;
                        end
                    end
                end else begin
                    m_run = 0;
                end
                m_seg_q = seg;
                m_dig_q = dig_n;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("dout",    32'(dout),    32'(m_dout));
                check("dvalid",  32'(dvalid),  32'(m_dvalid));
                check("bad",     32'(bad),     32'(m_bad));
                check("frame",   32'(frame),   32'(m_frame));
                check("err_cnt", 32'(err_cnt), 32'(m_err));
                if (frame === 1'b1) frame_cnt++;
                if (bad === 1'b1) bad_cnt++;
            end
        end
    end

    task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
        dig_n = d;
        seg   = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout"},   32'(dout),    32'h0);
        check({tag, "_dvalid"}, 32'(dvalid),  32'h0);
        check({tag, "_bad"},    32'(bad),     32'h0);
        check({tag, "_frame"},  32'(frame),   32'h0);
        check({tag, "_err"},    32'(err_cnt), 32'h0);
    endtask

    initial begin
        logic [3:0] d;
        logic [6:0] s;
        int         sel;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Legal digit: capture exactly 5 edges after the change.
        hold(4'b1110, 7'h30, 4);
        check("lat_before", 32'(dvalid), 32'h0);
        hold(4'b1110, 7'h30, 1);
        check("lat_dout", 32'(dout[3:0]), 32'h3);
        check("lat_dvalid", 32'(dvalid), 32'h1);
        check("lat_bad", 32'(bad), 32'h0);
        hold(4'b1110, 7'h30, 5);

        // Full frame, twice.
        for (int r = 0; r < 2; r++) begin
            hold(4'b1110, 7'h40, 8);
            hold(4'b1101, 7'h79, 8);
            hold(4'b1011, 7'h24, 8);
            hold(4'b0111, 7'h10, 8);
            check("frame_dout", 32'(dout), 32'h9210);
            check("frame_dvalid", 32'(dvalid), 32'hF);
            check("frame_count", 32'(frame_cnt), 32'(r + 1));
        end

        // Glitch rejection then a full-length change.
        hold(4'b1101, 7'h79, 8);
        hold(4'b1101, 7'h00, 2);
        check("glitch_mid", 32'(dout[7:4]), 32'h1);
        hold(4'b1101, 7'h79, 8);
        check("glitch_after", 32'(dout[7:4]), 32'h1);
        hold(4'b1101, 7'h00, 4);
        hold(4'b1101, 7'h79, 1);
        check("glitch_long", 32'(dout[7:4]), 32'h8);
        hold(4'b1101, 7'h79, 6);

        // Illegal, blank, then saturation.
        hold(4'b1011, 7'h55, 8);
        check("illegal_err", 32'(err_cnt), 32'h1);
        check("illegal_dvalid2", 32'(dvalid[2]), 32'h0);
        check("illegal_dout2", 32'(dout[11:8]), 32'h2);
        check("illegal_badcnt", 32'(bad_cnt), 32'h1);
        hold(4'b1011, 7'h7F, 8);
        check("blank_dvalid2", 32'(dvalid[2]), 32'h0);
        check("blank_badcnt", 32'(bad_cnt), 32'h1);
        for (int i = 0; i < 300; i++) hold(4'b1011, (i % 2 == 0) ? 7'h55 : 7'h56, 4);
        hold(4'b1011, 7'h7F, 2);
        check("err_saturate", 32'(err_cnt), 32'hFF);

        // Strobe errors abort the window.
        hold(4'b1110, 7'h12, 3);
        hold(4'b1100, 7'h12, 1);
        hold(4'b1110, 7'h12, 4);
        check("multi_low_nocap", 32'(dout[3:0]), 32'h0);
        hold(4'b1110, 7'h12, 1);
        check("multi_low_cap", 32'(dout[3:0]), 32'h5);
        hold(4'b1011, 7'h02, 2);
        hold(4'b1111, 7'h02, 1);
        hold(4'b1011, 7'h02, 4);
        check("all_high_nocap", 32'(dout[11:8]), 32'h2);
        hold(4'b1011, 7'h02, 1);
        check("all_high_cap", 32'(dout[11:8]), 32'h6);

        // Reset mid-window and right after a capture.
        hold(4'b0111, 7'h19, 2);
        rst = 1'b1;
        hold(4'b0111, 7'h19, 1);
        check_zero("rst_settle");
        rst = 1'b0;
        hold(4'b0111, 7'h19, 4);
        check("rst_nostale", 32'(dvalid), 32'h0);
        hold(4'b0111, 7'h19, 1);
        check("rst_recap_dout", 32'(dout[15:12]), 32'h4);
        check("rst_recap_dvalid", 32'(dvalid), 32'h8);
        rst = 1'b1;
        hold(4'b0111, 7'h19, 1);
        check_zero("rst_capture");
        rst = 1'b0;
        hold(4'b0111, 7'h19, 4);
        check("rst2_nostale", 32'(dvalid), 32'h0);
        hold(4'b0111, 7'h19, 3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 85) d = ~(4'b0001 << $urandom_range(0, 3));
            else d = 4'($urandom);
            sel = int'($urandom_range(0, 11));
            if (sel < 10) s = glyph(sel);
            else if (sel == 10) s = 7'h7F;
            else s = 7'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                hold(d, s, 1);
                rst = 1'b0;
            end
            hold(d, s, int'($urandom_range(1, 7)));
        end
        hold(4'hF, 7'h7F, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
